victim_cache_buffer: RTL and testbench

- Small fully-associative victim cache holding lines evicted from the write-back data cache.
- Responder side of the dcache/victim interface:
  - answers lookups with victim_hit_o and the line data;
  - accepts evicted lines on write_to_victim_i;
  - releases hit lines back to the dcache on write_from_victim_i.
- Dirty lines displaced from the buffer are written to data memory through a one-line writeback buffer.
- A flush drains the whole structure.

---
 rtl/victim_cache_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_victim_cache_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_buffer.sv
`default_nettype none
// ============================================================================
// Module   : victim_cache_buffer
// Brief    : Fully-associative victim cache behind a write-back dcache, with a
//            one-line writeback buffer to data memory and a flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module victim_cache_buffer #(
  parameter int ENTRIES = 4,
  parameter int LADDR_W = 28,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_req_i,
  input  logic [LADDR_W-1:0] lookup_addr_i,
  output logic               victim_hit_o,
  output logic [LINE_W-1:0]  rd_line_o,
  output logic               rd_dirty_o,
  input  logic               write_from_victim_i,
  input  logic               write_to_victim_i,
  input  logic [LADDR_W-1:0] wr_addr_i,
  input  logic [LINE_W-1:0]  wr_line_i,
  input  logic               wr_dirty_i,
  output logic               busy_o,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               vc2mem_req_o,
  output logic               vc2mem_wr_o,
  output logic [LADDR_W-1:0] vc2mem_addr_o,
  output logic [LINE_W-1:0]  vc2mem_line_o,
  input  logic               mem2vc_ack_i
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB       = 2'd1,
    FLUSH    = 2'd2,
    FLUSH_WB = 2'd3
  } state_t;

  state_t               state;
  logic [ENTRIES-1:0]   valid;
  logic [ENTRIES-1:0]   dirty;
  logic [LADDR_W-1:0]   addr [ENTRIES];
  logic [LINE_W-1:0]    line [ENTRIES];
  logic                 wb_valid;
  logic [LADDR_W-1:0]   wb_addr;
  logic [LINE_W-1:0]    wb_line;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 flush_done;

  logic                 hit_entry;
  logic [IDX_W-1:0]     hit_idx;
  logic                 wr_match;
  logic [IDX_W-1:0]     wr_match_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 flush_found;
  logic [IDX_W-1:0]     flush_idx;
  logic                 wb_hit;
  logic                 in_flush;
  logic                 hit_any;
  logic                 release_en;
  logic                 insert_en;
  logic                 use_rr;
  logic [IDX_W-1:0]     ins_idx;

  // Priority searches over the entries; descending scan so the lowest index wins.
  always_comb begin
    hit_entry    = 1'b0;
    hit_idx      = '0;
    wr_match     = 1'b0;
    wr_match_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    flush_found  = 1'b0;
    flush_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (addr[i] == lookup_addr_i)) begin
        hit_entry = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (valid[i] && (addr[i] == wr_addr_i)) begin
        wr_match     = 1'b1;
        wr_match_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end else begin
        flush_found = 1'b1;
        flush_idx   = IDX_W'(i);
      end
    end
  end

  assign wb_hit     = wb_valid && (wb_addr == lookup_addr_i);
  assign in_flush   = (state == FLUSH) || (state == FLUSH_WB);
  assign hit_any    = lookup_req_i && (hit_entry || wb_hit) && !in_flush;
  // A wb-buffer hit is never released: the writeback already owns that line.
  assign release_en = write_from_victim_i && hit_any && hit_entry;
  assign insert_en  = write_to_victim_i && !wb_valid && (state == IDLE);

  // Insert slot choice: same address, then the slot freed this cycle, then a hole, then round-robin.
  always_comb begin
    ins_idx = rr_ptr;
    use_rr  = 1'b0;
    if (wr_match) begin
      ins_idx = wr_match_idx;
    end else if (release_en) begin
      ins_idx = hit_idx;
    end else if (free_found) begin
      ins_idx = free_idx;
    end else begin
      use_rr = 1'b1;
    end
  end

  // Entry storage, writeback buffer and the writeback/flush state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      wb_valid   <= 1'b0;
      rr_ptr     <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;

      if (release_en) begin
        valid[hit_idx] <= 1'b0;
      end

      if (insert_en) begin
        valid[ins_idx] <= 1'b1;
        addr[ins_idx]  <= wr_addr_i;
        line[ins_idx]  <= wr_line_i;
        dirty[ins_idx] <= wr_match ? (dirty[ins_idx] | wr_dirty_i) : wr_dirty_i;
        if (use_rr) begin
          rr_ptr <= rr_ptr + IDX_W'(1);
          // The round-robin victim is always valid here; only dirty data needs memory.
          if (dirty[rr_ptr]) begin
            wb_valid <= 1'b1;
            wb_addr  <= addr[rr_ptr];
            wb_line  <= line[rr_ptr];
          end
        end
      end

      case (state)
        IDLE: begin
          if (flush_i) begin
            state <= wb_valid ? FLUSH_WB : FLUSH;
          end else if (wb_valid) begin
            state <= WB;
          end
        end
        WB: begin
          if (mem2vc_ack_i) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        FLUSH: begin
          if (wb_valid) begin
            // A line displaced by an insert accepted on the flush-start edge.
            state <= FLUSH_WB;
          end else if (flush_found) begin
            valid[flush_idx] <= 1'b0;
            if (dirty[flush_idx]) begin
              wb_valid <= 1'b1;
              wb_addr  <= addr[flush_idx];
              wb_line  <= line[flush_idx];
              state    <= FLUSH_WB;
            end
          end else begin
            flush_done <= 1'b1;
            rr_ptr     <= '0;
            state      <= IDLE;
          end
        end
        FLUSH_WB: begin
          if (mem2vc_ack_i) begin
            wb_valid <= 1'b0;
            state    <= FLUSH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, whatever the storage contains.
  assign victim_hit_o  = rst_n && hit_any;
  assign rd_line_o     = !rst_n ? '0 : (hit_entry ? line[hit_idx] : wb_line);
  assign rd_dirty_o    = !rst_n ? 1'b0 : (hit_entry ? dirty[hit_idx] : wb_hit);
  assign busy_o        = rst_n && (wb_valid || (state != IDLE));
  assign flush_done_o  = rst_n && flush_done;
  assign vc2mem_req_o  = rst_n && ((state == WB) || (state == FLUSH_WB));
  assign vc2mem_wr_o   = vc2mem_req_o;
  assign vc2mem_addr_o = !rst_n ? '0 : wb_addr;
  assign vc2mem_line_o = !rst_n ? '0 : wb_line;

endmodule
`default_nettype wire

// File: tb/tb_victim_cache_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_victim_cache_buffer
// Brief    : Directed plus random bench for victim_cache_buffer, compared each
//            cycle against a rule-level model of the victim cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_victim_cache_buffer;

  localparam int ENTRIES = 4;
  localparam int LADDR_W = 28;
  localparam int LINE_W  = 128;

  localparam int P_IDLE = 0, P_WB = 1, P_FLUSH = 2, P_FLUSH_WB = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               lookup_req;
  logic [LADDR_W-1:0] lookup_addr;
  logic               victim_hit;
  logic [LINE_W-1:0]  rd_line;
  logic               rd_dirty;
  logic               write_from_victim;
  logic               write_to_victim;
  logic [LADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0]  wr_line;
  logic               wr_dirty;
  logic               busy;
  logic               flush;
  logic               flush_done;
  logic               vc2mem_req;
  logic               vc2mem_wr;
  logic [LADDR_W-1:0] vc2mem_addr;
  logic [LINE_W-1:0]  vc2mem_line;
  logic               mem2vc_ack;

  victim_cache_buffer #(.ENTRIES(ENTRIES), .LADDR_W(LADDR_W), .LINE_W(LINE_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_req_i        (lookup_req),
    .lookup_addr_i       (lookup_addr),
    .victim_hit_o        (victim_hit),
    .rd_line_o           (rd_line),
    .rd_dirty_o          (rd_dirty),
    .write_from_victim_i (write_from_victim),
    .write_to_victim_i   (write_to_victim),
    .wr_addr_i           (wr_addr),
    .wr_line_i           (wr_line),
    .wr_dirty_i          (wr_dirty),
    .busy_o              (busy),
    .flush_i             (flush),
    .flush_done_o        (flush_done),
    .vc2mem_req_o        (vc2mem_req),
    .vc2mem_wr_o         (vc2mem_wr),
    .vc2mem_addr_o       (vc2mem_addr),
    .vc2mem_line_o       (vc2mem_line),
    .mem2vc_ack_i        (mem2vc_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed memory traffic and flush completions.
  int                 wr_cnt   = 0;
  int                 done_cnt = 0;
  logic [LADDR_W-1:0] wr_addrs [$];

  // Reference model: contents of the victim cache as the rules define them.
  bit                 m_valid [ENTRIES];
  bit                 m_dirty [ENTRIES];
  logic [LADDR_W-1:0] m_addr  [ENTRIES];
  logic [LINE_W-1:0]  m_line  [ENTRIES];
  bit                 m_wbv;
  logic [LADDR_W-1:0] m_wba;
  logic [LINE_W-1:0]  m_wbl;
  int                 m_rr;
  int                 m_phase;
  bit                 m_done;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_wbv = 0; m_rr = 0; m_phase = P_IDLE; m_done = 0;
  endtask

  task automatic model_lookup(output bit hit, output bit from_entry, output int idx,
                              output logic [LINE_W-1:0] ln, output bit dty);
    hit = 0; from_entry = 0; idx = 0; ln = '0; dty = 0;
    if (!lookup_req || m_phase == P_FLUSH || m_phase == P_FLUSH_WB) return;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && m_addr[i] == lookup_addr) begin
        hit = 1; from_entry = 1; idx = i; ln = m_line[i]; dty = m_dirty[i];
        return;
      end
    end
    if (m_wbv && m_wba == lookup_addr) begin
      hit = 1; ln = m_wbl; dty = 1;
    end
  endtask

  task automatic check_outputs();
    bit h, fe, dt, req;
    int hi;
    logic [LINE_W-1:0] ln;
    if (!rst_n) begin
      chk("rst_hit", victim_hit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_req", vc2mem_req, 0);
      chk("rst_wr", vc2mem_wr, 0);
      chk("rst_rd_line", rd_line, 0);
      chk("rst_rd_dirty", rd_dirty, 0);
      chk("rst_mem_addr", vc2mem_addr, 0);
      chk("rst_mem_line", vc2mem_line, 0);
      return;
    end
    model_lookup(h, fe, hi, ln, dt);
    chk("hit", victim_hit, h);
    if (h) begin
      chk("rd_line", rd_line, ln);
      chk("rd_dirty", rd_dirty, dt);
    end
    chk("busy", busy, (m_wbv || m_phase != P_IDLE));
    req = (m_phase == P_WB) || (m_phase == P_FLUSH_WB);
    chk("req", vc2mem_req, req);
    chk("wr", vc2mem_wr, req);
    if (req) begin
      chk("mem_addr", vc2mem_addr, m_wba);
      chk("mem_line", vc2mem_line, m_wbl);
    end
    chk("flush_done", flush_done, m_done);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit h, fe, dt, busy_now, pre_wbv, rel, merge;
    int hi, slot, k;
    logic [LINE_W-1:0] ln;
    if (!rst_n) begin
      model_reset();
      return;
    end
    model_lookup(h, fe, hi, ln, dt);
    busy_now = m_wbv || (m_phase != P_IDLE);
    pre_wbv  = m_wbv;
    rel      = write_from_victim && h && fe;
    m_done   = 0;
    slot     = -1;
    merge    = 0;
    if (write_to_victim && !busy_now) begin
      for (int i = 0; i < ENTRIES; i++)
        if (slot < 0 && m_valid[i] && m_addr[i] == wr_addr) begin slot = i; merge = 1; end
      if (slot < 0 && rel) slot = hi;
      for (int i = 0; i < ENTRIES; i++)
        if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) begin
        slot = m_rr;
        if (m_dirty[slot]) begin m_wbv = 1; m_wba = m_addr[slot]; m_wbl = m_line[slot]; end
        m_rr = (m_rr + 1) % ENTRIES;
      end
    end
    if (rel) m_valid[hi] = 0;
    if (slot >= 0) begin
      m_dirty[slot] = merge ? (m_dirty[slot] | wr_dirty) : wr_dirty;
      m_valid[slot] = 1;
      m_addr[slot]  = wr_addr;
      m_line[slot]  = wr_line;
    end
    case (m_phase)
      P_IDLE: begin
        if (flush) m_phase = pre_wbv ? P_FLUSH_WB : P_FLUSH;
        else if (pre_wbv) m_phase = P_WB;
      end
      P_WB: if (mem2vc_ack) begin m_wbv = 0; m_phase = P_IDLE; end
      P_FLUSH: begin
        if (pre_wbv) m_phase = P_FLUSH_WB;
        else begin
          k = -1;
          for (int i = 0; i < ENTRIES; i++) if (k < 0 && m_valid[i]) k = i;
          if (k >= 0) begin
            m_valid[k] = 0;
            if (m_dirty[k]) begin
              m_wbv = 1; m_wba = m_addr[k]; m_wbl = m_line[k]; m_phase = P_FLUSH_WB;
            end
          end else begin
            m_done = 1; m_rr = 0; m_phase = P_IDLE;
          end
        end
      end
      default: if (mem2vc_ack) begin m_wbv = 0; m_phase = P_FLUSH; end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (vc2mem_req && mem2vc_ack) begin
      wr_cnt++;
      wr_addrs.push_back(vc2mem_addr);
    end
    if (flush_done) done_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic ins(input int a, input bit d);
    write_to_victim = 1; wr_addr = LADDR_W'(a); wr_dirty = d; wr_line = rnd_line();
    cycle();
    write_to_victim = 0;
  endtask

  task automatic look(input int a);
    lookup_req = 1; lookup_addr = LADDR_W'(a);
    cycle();
    lookup_req = 0;
  endtask

  task automatic do_flush();
    wr_cnt = 0; done_cnt = 0; wr_addrs.delete();
    mem2vc_ack = 1; flush = 1;
    cycle();
    flush = 0;
    for (int k = 0; k < 60 && done_cnt == 0; k++) cycle();
    cycle();
    mem2vc_ack = 0;
  endtask

  initial begin
    rst_n = 0; lookup_req = 1; lookup_addr = 28'h10; write_from_victim = 0;
    write_to_victim = 1; wr_addr = 28'h10; wr_line = '1; wr_dirty = 1;
    flush = 0; mem2vc_ack = 0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) cycle();
    rst_n = 1; lookup_req = 0; write_to_victim = 0;

    // Basic insert and lookup.
    ins(32'h10, 0);
    ins(32'h20, 1);
    look(32'h20);
    chk("lookup_b_hit", victim_hit, 1);
    chk("lookup_b_dirty", rd_dirty, 1);
    look(32'h30);
    chk("lookup_miss", victim_hit, 0);

    // Clean fill then round-robin replacement without writeback.
    do_flush();
    for (int a = 1; a <= 4; a++) ins(a * 16, 0);
    ins(32'h50, 0);
    chk("clean_evict_busy", busy, 0);
    ins(32'h60, 0);
    look(32'h10);
    look(32'h20);
    look(32'h60);
    repeat (3) cycle();
    chk("clean_evict_req", vc2mem_req, 0);

    // Dirty fill; displaced slot 0 goes to memory with a delayed ack.
    do_flush();
    for (int a = 1; a <= 4; a++) ins(a * 16, 1);
    mem2vc_ack = 0;
    ins(32'h50, 1);
    chk("wb_busy", busy, 1);
    cycle();
    chk("wb_req", vc2mem_req, 1);
    chk("wb_addr", vc2mem_addr, 28'h10);
    cycle();
    cycle();
    chk("wb_req_held", vc2mem_req, 1);
    mem2vc_ack = 1;
    cycle();
    mem2vc_ack = 0;
    chk("wb_done_busy", busy, 0);
    chk("wb_done_req", vc2mem_req, 0);

    // Release of 0x20 and insert of 0x60 in the same cycle share slot 1.
    lookup_req = 1; lookup_addr = 28'h20; write_from_victim = 1;
    write_to_victim = 1; wr_addr = 28'h60; wr_dirty = 1; wr_line = rnd_line();
    cycle();
    lookup_req = 0; write_from_victim = 0; write_to_victim = 0;
    chk("swap_no_wb", busy, 0);
    look(32'h60);
    look(32'h20);
    chk("swap_released", victim_hit, 0);

    // Re-insert of an existing address merges dirty in place.
    do_flush();
    ins(32'h10, 0);
    ins(32'h20, 0);
    ins(32'h10, 1);
    look(32'h10);
    chk("merge_dirty", rd_dirty, 1);
    ins(32'h30, 0);
    ins(32'h30, 1);

    // Flush with two dirty and one clean entry; lookups must miss meanwhile.
    lookup_addr = 28'h10;
    wr_cnt = 0; done_cnt = 0; wr_addrs.delete();
    mem2vc_ack = 1; flush = 1;
    cycle();
    flush = 0; lookup_req = 1;
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      chk("flush_lookup_miss", victim_hit, 0);
      cycle();
    end
    lookup_req = 0; mem2vc_ack = 0;
    chk("flush_writes", wr_cnt, 2);
    chk("flush_done_pulses", done_cnt, 1);
    if (wr_addrs.size() >= 2) begin
      chk("flush_order0", wr_addrs[0], 28'h10);
      chk("flush_order1", wr_addrs[1], 28'h30);
    end
    cycle();
    chk("flush_done_single", flush_done, 0);

    // Reset while a writeback is pending abandons it.
    for (int a = 1; a <= 4; a++) ins(a * 16, 1);
    ins(32'h70, 1);
    for (int k = 0; k < 5 && m_phase != P_WB; k++) cycle();
    chk("pre_reset_req", vc2mem_req, 1);
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
    cycle();
    chk("post_reset_req", vc2mem_req, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 999);
      rst_n             = (r >= 5);
      lookup_req        = ($urandom_range(0, 1) == 1);
      lookup_addr       = LADDR_W'($urandom_range(1, 8) * 16);
      write_from_victim = ($urandom_range(0, 3) == 0);
      write_to_victim   = ($urandom_range(0, 2) == 0);
      wr_addr           = LADDR_W'($urandom_range(1, 8) * 16);
      wr_dirty          = ($urandom_range(0, 1) == 1);
      wr_line           = rnd_line();
      flush             = (r >= 5 && r < 25);
      mem2vc_ack        = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
